// File: rtl/ssp_reg_resp_if.sv
// SSP register-access bus between the initiator and the responder.
interface ssp_reg_resp_if;
  logic        SSP_SSEL;
  logic        SSP_EOC;
  logic [2:0]  SSP_RA;
  logic        SSP_WnR;
  logic [11:0] SSP_DI;
  logic [11:0] SSP_DO;

  modport master (
    output SSP_SSEL, SSP_EOC, SSP_RA,
    output SSP_WnR, SSP_DI,
    input  SSP_DO
  );

  modport slave (
    input  SSP_SSEL, SSP_EOC, SSP_RA,
    input  SSP_WnR, SSP_DI,
    output SSP_DO
  );
endinterface

// File: rtl/ssp_reg_resp.sv
// SSP register responder: UART register map, TX/RX FIFOs, loopback, irq.
module ssp_reg_resp #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  ssp_reg_resp_if.slave ssp,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  output logic          irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] FULL = 4'(DEPTH);

  logic [11:0]   ucr_q, ucr_d;
  logic [11:0]   spr_q, spr_d;
  logic [11:0]   tdr_q, tdr_d;
  logic [11:0]   do_q, do_d;
  logic          irq_q, irq_d;
  logic          ovf_q, ovf_d;

  logic [DW-1:0] tx_mem_q [DEPTH];
  logic [DW-1:0] rx_mem_q [DEPTH];
  logic [AW-1:0] tx_wp_q, tx_rp_q;
  logic [AW-1:0] rx_wp_q, rx_rp_q;
  logic [3:0]    tx_cnt_q, tx_cnt_d;
  logic [3:0]    rx_cnt_q, rx_cnt_d;

  logic acc, wr, rd;
  logic sel_ucr, sel_usr, sel_tdr;
  logic sel_rdr, sel_spr;
  logic tx_empty, tx_full;
  logic rx_empty, rx_full;
  logic tx_push, tx_pop;
  logic rx_push, rx_pop;
  logic lb, lb_mv, rx_in_v, ovf_set;
  logic [DW-1:0] tx_head, rx_head, rx_in;
  logic [11:0]   usr, rdata;

  assign acc = ssp.SSP_SSEL & ssp.SSP_EOC;
  assign wr  = acc & ssp.SSP_WnR;
  assign rd  = acc & ~ssp.SSP_WnR;

  assign sel_ucr = ssp.SSP_RA == 3'd0;
  assign sel_usr = ssp.SSP_RA == 3'd1;
  assign sel_tdr = ssp.SSP_RA == 3'd2;
  assign sel_rdr = ssp.SSP_RA == 3'd3;
  assign sel_spr = ssp.SSP_RA == 3'd4;

  assign tx_empty = tx_cnt_q == 4'd0;
  assign tx_full  = tx_cnt_q == FULL;
  assign rx_empty = rx_cnt_q == 4'd0;
  assign rx_full  = rx_cnt_q == FULL;
  assign tx_head  = tx_mem_q[tx_rp_q];
  assign rx_head  = rx_mem_q[rx_rp_q];

  assign lb       = ucr_q[2];
  assign tx_valid = ucr_q[0] & ~lb & ~tx_empty;
  assign tx_data  = tx_head;

  // A pop in the same cycle frees a slot for the incoming byte.
  assign rx_pop  = rd & sel_rdr & ~rx_empty;
  assign lb_mv   = lb & ~tx_empty
                 & (~rx_full | rx_pop);
  assign rx_in_v = lb ? lb_mv
                 : (ucr_q[1] & rx_valid);
  assign rx_in   = lb ? tx_head : rx_data;
  assign rx_push = rx_in_v & (~rx_full | rx_pop);
  assign ovf_set = rx_in_v & rx_full & ~rx_pop;

  assign tx_push = wr & sel_tdr & ~tx_full;
  assign tx_pop  = (tx_valid & tx_ready) | lb_mv;

  assign usr = {tx_cnt_q, rx_cnt_q, ovf_q,
                ~rx_empty, tx_full, tx_empty};

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_ucr: rdata = ucr_q;
      sel_usr: rdata = usr;
      sel_tdr: rdata = tdr_q;
      sel_rdr: rdata = rx_empty ? 12'h000
             : {{(12-DW){1'b0}}, rx_head};
      sel_spr: rdata = spr_q;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    ucr_d = ucr_q;
    spr_d = spr_q;
    tdr_d = tdr_q;
    if (wr && sel_ucr) ucr_d = ssp.SSP_DI;
    if (wr && sel_spr) spr_d = ssp.SSP_DI;
    if (wr && sel_tdr) tdr_d = ssp.SSP_DI;
    do_d = ssp.SSP_SSEL ? rdata : 12'h000;
    ovf_d = ovf_q;
    if (wr && sel_usr && ssp.SSP_DI[3])
      ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    tx_cnt_d = tx_cnt_q + {3'b0, tx_push}
             - {3'b0, tx_pop};
    rx_cnt_d = rx_cnt_q + {3'b0, rx_push}
             - {3'b0, rx_pop};
    irq_d = (ucr_q[4] & tx_empty)
          | (ucr_q[5] & ~rx_empty)
          | (ucr_q[6] & ovf_q);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ucr_q    <= '0;
      spr_q    <= '0;
      tdr_q    <= '0;
      do_q     <= '0;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      ucr_q    <= ucr_d;
      spr_q    <= spr_d;
      tdr_q    <= tdr_d;
      do_q     <= do_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
    end
  end

  // Storage needs no reset; the pointers and counts define validity.
  always_ff @(posedge Clk) begin
    if (tx_push)
      tx_mem_q[tx_wp_q] <= ssp.SSP_DI[DW-1:0];
    if (rx_push)
      rx_mem_q[rx_wp_q] <= rx_in;
  end

  assign ssp.SSP_DO = do_q;
  assign irq        = irq_q;

endmodule
